// File: rtl/ysyx_22040750_pkg.sv
// Shared types for the NPC memory arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE / REQ / RESP)
//   owner_t     : which pipeline stage owns the bus (IF or MEM)
package ysyx_22040750_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/ysyx_22040750_arb_pick.sv
// Combinational tie-break between the IF and MEM requesters.
// Ports:
//   if_elig, mem_elig : requester is eligible this cycle
//   last_winner       : owner of the most recent grant
//   any_elig          : at least one requester eligible
//   winner            : selected owner (meaningful only when any_elig)
module ysyx_22040750_arb_pick
    import ysyx_22040750_pkg::*;
#(
    parameter int unsigned MEM_PRIO = 1
) (
    input  logic   if_elig,
    input  logic   mem_elig,
    input  owner_t last_winner,
    output logic   any_elig,
    output owner_t winner
);

    always_comb begin
        any_elig = if_elig | mem_elig;
        winner   = OWN_IF;
        if (if_elig && mem_elig) begin
            if (MEM_PRIO != 0) begin
                winner = OWN_MEM;
            end else begin
                // Round-robin: whoever did not win last time.
                winner = (last_winner == OWN_IF) ? OWN_MEM : OWN_IF;
            end
        end else if (mem_elig) begin
            winner = OWN_MEM;
        end
    end

endmodule

// File: rtl/ysyx_22040750_mem_arbiter.sv
// Arbitrates the single core-side memory bus between instruction fetch
// (read-only) and the MEM stage. One transaction in flight at a time; the
// winner owns the bus from command issue through response.
//
// State table:
//   ARB_IDLE | no transaction; arbitrate and latch the winner's command
//   ARB_REQ  | O_bus_req high, waiting for I_bus_ready (grant)
//   ARB_RESP | command accepted, waiting for I_bus_rvalid
//
// Ports:
//   I_sys_clk, I_rst        : clock, asynchronous active-high reset
//   I_flush                 : squash current/pending IF transaction
//   I_if_*  / O_if_*        : fetch request, grant, response
//   I_mem_* / O_mem_*       : load/store request, grant, response / write ack
//   O_bus_*                 : registered bus command
//   I_bus_ready/rvalid/rdata: bus handshake and response
//   O_busy                  : state != IDLE
module ysyx_22040750_mem_arbiter
    import ysyx_22040750_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 64,
    parameter int unsigned MEM_PRIO = 1
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_flush,

    input  logic            I_if_req,
    input  logic [AW-1:0]   I_if_addr,
    output logic            O_if_gnt,
    output logic            O_if_rvalid,
    output logic [DW-1:0]   O_if_rdata,

    input  logic            I_mem_req,
    input  logic            I_mem_wen,
    input  logic [AW-1:0]   I_mem_addr,
    input  logic [DW-1:0]   I_mem_wdata,
    input  logic [DW/8-1:0] I_mem_wstrb,
    output logic            O_mem_gnt,
    output logic            O_mem_rvalid,
    output logic [DW-1:0]   O_mem_rdata,

    output logic            O_bus_req,
    output logic            O_bus_wen,
    output logic [AW-1:0]   O_bus_addr,
    output logic [DW-1:0]   O_bus_wdata,
    output logic [DW/8-1:0] O_bus_wstrb,
    input  logic            I_bus_ready,
    input  logic            I_bus_rvalid,
    input  logic [DW-1:0]   I_bus_rdata,

    output logic            O_busy
);

    arb_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    owner_t          last_winner_q, last_winner_d;
    logic            drop_q, drop_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_wen_q, bus_wen_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DW/8-1:0] bus_wstrb_q, bus_wstrb_d;

    logic   any_elig;
    owner_t winner;
    logic   gnt_fire;
    logic   resp_fire;

    ysyx_22040750_arb_pick #(
        .MEM_PRIO (MEM_PRIO)
    ) u_pick (
        .if_elig     (I_if_req && !I_flush),
        .mem_elig    (I_mem_req),
        .last_winner (last_winner_q),
        .any_elig    (any_elig),
        .winner      (winner)
    );

    assign gnt_fire  = (state_q == ARB_REQ)  && I_bus_ready;
    assign resp_fire = (state_q == ARB_RESP) && I_bus_rvalid;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        drop_d        = drop_q;
        bus_req_d     = bus_req_q;
        bus_wen_d     = bus_wen_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wstrb_d   = bus_wstrb_q;

        // A flushed fetch cannot be retracted from the bus, so remember to
        // swallow its grant/response instead.
        if (I_flush && owner_q == OWN_IF && state_q != ARB_IDLE) begin
            drop_d = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (any_elig) begin
                    state_d   = ARB_REQ;
                    bus_req_d = 1'b1;
                    owner_d   = winner;
                    if (winner == OWN_MEM) begin
                        bus_wen_d   = I_mem_wen;
                        bus_addr_d  = I_mem_addr;
                        bus_wdata_d = I_mem_wdata;
                        bus_wstrb_d = I_mem_wstrb;
                    end else begin
                        bus_wen_d   = 1'b0;
                        bus_addr_d  = I_if_addr;
                        bus_wdata_d = '0;
                        bus_wstrb_d = '0;
                    end
                end
            end
            ARB_REQ: begin
                if (I_bus_ready) begin
                    state_d       = ARB_RESP;
                    bus_req_d     = 1'b0;
                    last_winner_d = owner_q;
                end
            end
            ARB_RESP: begin
                if (I_bus_rvalid) begin
                    state_d = ARB_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= OWN_IF;
            last_winner_q <= OWN_IF;
            drop_q        <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_wen_q     <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_wstrb_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            drop_q        <= drop_d;
            bus_req_q     <= bus_req_d;
            bus_wen_q     <= bus_wen_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wstrb_q   <= bus_wstrb_d;
        end
    end

    // A flush landing in the same cycle as the grant or response must also
    // suppress it, hence the live I_flush term next to drop_q.
    assign O_if_gnt     = gnt_fire  && owner_q == OWN_IF  && !drop_q && !I_flush;
    assign O_mem_gnt    = gnt_fire  && owner_q == OWN_MEM;
    assign O_if_rvalid  = resp_fire && owner_q == OWN_IF  && !drop_q && !I_flush;
    assign O_mem_rvalid = resp_fire && owner_q == OWN_MEM;

    assign O_if_rdata  = (state_q == ARB_RESP && owner_q == OWN_IF)  ? I_bus_rdata : '0;
    assign O_mem_rdata = (state_q == ARB_RESP && owner_q == OWN_MEM) ? I_bus_rdata : '0;

    assign O_bus_req   = bus_req_q;
    assign O_bus_wen   = bus_wen_q;
    assign O_bus_addr  = bus_addr_q;
    assign O_bus_wdata = bus_wdata_q;
    assign O_bus_wstrb = bus_wstrb_q;
    assign O_busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ysyx_22040750_mem_arbiter.sv
module tb_ysyx_22040750_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_wstrb = '0;
    logic        bus_ready = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [63:0] bus_rdata = 64'hA5A5_5A5A_DEAD_BEEF;

    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
    logic [63:0] if_rdata, mem_rdata, bus_wdata;
    logic        bus_req, bus_wen, busy;
    logic [31:0] bus_addr;
    logic [7:0]  bus_wstrb;

    logic        r_if_gnt, r_if_rvalid, r_mem_gnt, r_mem_rvalid;
    logic [63:0] r_if_rdata, r_mem_rdata, r_bus_wdata;
    logic        r_bus_req, r_bus_wen, r_busy;
    logic [31:0] r_bus_addr;
    logic [7:0]  r_bus_wstrb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22040750_mem_arbiter #(.AW(32), .DW(64), .MEM_PRIO(1)) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_flush(flush),
        .I_if_req(if_req), .I_if_addr(if_addr),
        .O_if_gnt(if_gnt), .O_if_rvalid(if_rvalid), .O_if_rdata(if_rdata),
        .I_mem_req(mem_req), .I_mem_wen(mem_wen), .I_mem_addr(mem_addr),
        .I_mem_wdata(mem_wdata), .I_mem_wstrb(mem_wstrb),
        .O_mem_gnt(mem_gnt), .O_mem_rvalid(mem_rvalid), .O_mem_rdata(mem_rdata),
        .O_bus_req(bus_req), .O_bus_wen(bus_wen), .O_bus_addr(bus_addr),
        .O_bus_wdata(bus_wdata), .O_bus_wstrb(bus_wstrb),
        .I_bus_ready(bus_ready), .I_bus_rvalid(bus_rvalid), .I_bus_rdata(bus_rdata),
        .O_busy(busy)
    );

    ysyx_22040750_mem_arbiter #(.AW(32), .DW(64), .MEM_PRIO(0)) dut_rr (
        .I_sys_clk(clk), .I_rst(rst), .I_flush(flush),
        .I_if_req(if_req), .I_if_addr(if_addr),
        .O_if_gnt(r_if_gnt), .O_if_rvalid(r_if_rvalid), .O_if_rdata(r_if_rdata),
        .I_mem_req(mem_req), .I_mem_wen(mem_wen), .I_mem_addr(mem_addr),
        .I_mem_wdata(mem_wdata), .I_mem_wstrb(mem_wstrb),
        .O_mem_gnt(r_mem_gnt), .O_mem_rvalid(r_mem_rvalid), .O_mem_rdata(r_mem_rdata),
        .O_bus_req(r_bus_req), .O_bus_wen(r_bus_wen), .O_bus_addr(r_bus_addr),
        .O_bus_wdata(r_bus_wdata), .O_bus_wstrb(r_bus_wstrb),
        .I_bus_ready(bus_ready), .I_bus_rvalid(bus_rvalid), .I_bus_rdata(bus_rdata),
        .O_busy(r_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset values ----------------
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wen", bus_wen, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_mem_rvalid", mem_rvalid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- IF only, minimum latency ----------------
        @(negedge clk);                     // cycle 0
        if_req = 1'b1; if_addr = 32'h8000_0000;
        #1 chk("t1_c0_busy", busy, 0);
        @(negedge clk);                     // cycle 1
        bus_ready = 1'b1;
        #1;
        chk("t1_bus_req", bus_req, 1);
        chk("t1_bus_addr", bus_addr, 64'h8000_0000);
        chk("t1_bus_wen", bus_wen, 0);
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_mem_gnt", mem_gnt, 0);
        @(negedge clk);                     // cycle 2
        bus_ready = 1'b0; if_req = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 64'h0000_0013_0000_0013;
        #1;
        chk("t1_bus_req_clr", bus_req, 0);
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 64'h0000_0013_0000_0013);
        chk("t1_mem_rvalid", mem_rvalid, 0);
        chk("t1_mem_rdata", mem_rdata, 0);
        @(negedge clk);                     // cycle 3
        bus_rvalid = 1'b0;
        #1 chk("t1_c3_busy", busy, 0);

        // ---------------- tie, MEM_PRIO=1 ----------------
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h8000_0004;
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h8000_1000;
        mem_wdata = 64'h1122_3344_5566_7788; mem_wstrb = 8'h0F;
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        chk("t2_bus_wen", bus_wen, 1);
        chk("t2_bus_wstrb", bus_wstrb, 8'h0F);
        chk("t2_bus_addr", bus_addr, 64'h8000_1000);
        chk("t2_bus_wdata", bus_wdata, 64'h1122_3344_5566_7788);
        chk("t2_mem_gnt", mem_gnt, 1);
        chk("t2_if_gnt", if_gnt, 0);
        @(negedge clk);
        bus_ready = 1'b0; mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h77;
        #1;
        chk("t2_mem_ack", mem_rvalid, 1);
        chk("t2_if_rvalid_n", if_rvalid, 0);
        chk("t2_if_rdata_n", if_rdata, 0);
        @(negedge clk);                     // bubble, IF arbitrated here
        bus_rvalid = 1'b0;
        #1 chk("t2_bubble", busy, 0);
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        chk("t2_if_addr", bus_addr, 64'h8000_0004);
        chk("t2_if_wen", bus_wen, 0);
        chk("t2_if_wstrb", bus_wstrb, 0);
        chk("t2_if_wdata", bus_wdata, 0);
        chk("t2_if_gnt", if_gnt, 1);
        @(negedge clk);
        bus_ready = 1'b0; if_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h1234;
        #1;
        chk("t2_if_rvalid", if_rvalid, 1);
        chk("t2_if_rdata", if_rdata, 64'h1234);
        @(negedge clk);
        bus_rvalid = 1'b0;
        mem_wen = 1'b0; mem_wstrb = 8'h00;

        // ---------------- round-robin (MEM_PRIO=0) ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if_req = 1'b1; mem_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            bus_ready = 1'b1;
            #1;
            chk($sformatf("rr_mem_gnt%0d", t), r_mem_gnt, (t % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_if_gnt%0d", t), r_if_gnt, (t % 2 == 0) ? 0 : 1);
            @(negedge clk);
            bus_ready = 1'b0; bus_rvalid = 1'b1;
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (t == 3) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        @(negedge clk);
        #1 chk("rr_idle", r_busy, 0);

        // ---------------- flush in RESP ----------------
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h8000_0010;
        @(negedge clk);
        bus_ready = 1'b1;
        #1 chk("f1_gnt", if_gnt, 1);
        @(negedge clk);
        bus_ready = 1'b0; if_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h99;
        #1;
        chk("f1_rvalid_drop", if_rvalid, 0);
        chk("f1_busy", busy, 1);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1 chk("f1_done", busy, 0);
        if_req = 1'b1; if_addr = 32'h8000_0018;
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        chk("f1_next_addr", bus_addr, 64'h8000_0018);
        chk("f1_next_gnt", if_gnt, 1);
        @(negedge clk);
        bus_ready = 1'b0; if_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h55;
        #1 chk("f1_next_rvalid", if_rvalid, 1);
        @(negedge clk);
        bus_rvalid = 1'b0;

        // flush in the same cycle as the grant
        if_req = 1'b1;
        @(negedge clk);
        bus_ready = 1'b1; flush = 1'b1;
        #1 chk("f2_gnt_supp", if_gnt, 0);
        @(negedge clk);
        bus_ready = 1'b0; flush = 1'b0; if_req = 1'b0; bus_rvalid = 1'b1;
        #1 chk("f2_rvalid_drop", if_rvalid, 0);
        @(negedge clk);
        bus_rvalid = 1'b0;

        // flush in the same cycle as the response
        if_req = 1'b1;
        @(negedge clk);
        bus_ready = 1'b1;
        #1 chk("f3_gnt", if_gnt, 1);
        @(negedge clk);
        bus_ready = 1'b0; if_req = 1'b0; bus_rvalid = 1'b1; flush = 1'b1;
        #1 chk("f3_rvalid_supp", if_rvalid, 0);
        @(negedge clk);
        bus_rvalid = 1'b0; flush = 1'b0;

        // flush in IDLE makes IF ineligible
        if_req = 1'b1; flush = 1'b1;
        @(negedge clk);
        if_req = 1'b0; flush = 1'b0;
        #1 chk("f4_not_started", busy, 0);

        // ---------------- ready stalled 5 cycles ----------------
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h8000_2000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("st_req%0d", i), bus_req, 1);
            chk($sformatf("st_addr%0d", i), bus_addr, 64'h8000_2000);
            chk($sformatf("st_gnt%0d", i), mem_gnt, 0);
        end
        @(negedge clk);
        bus_ready = 1'b1;
        #1 chk("st_gnt", mem_gnt, 1);
        @(negedge clk);
        bus_ready = 1'b0; mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hCAFE_F00D;
        #1;
        chk("st_rvalid", mem_rvalid, 1);
        chk("st_rdata", mem_rdata, 64'hCAFE_F00D);
        @(negedge clk);
        bus_rvalid = 1'b0;

        // ---------------- stray rvalid in IDLE ----------------
        @(negedge clk);
        bus_rvalid = 1'b1;
        #1;
        chk("idle_rv_if", if_rvalid, 0);
        chk("idle_rv_mem", mem_rvalid, 0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1 chk("idle_rv_busy", busy, 0);

        // ---------------- reset mid-RESP ----------------
        mem_req = 1'b1; mem_addr = 32'h8000_3000;
        @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0; mem_req = 1'b0;
        #1 chk("mr_busy", busy, 1);
        bus_rvalid = 1'b1; bus_rdata = 64'h1111;
        #2 rst = 1'b1;
        #1;
        chk("mr_busy_rst", busy, 0);
        chk("mr_addr_rst", bus_addr, 0);
        chk("mr_rvalid_rst", mem_rvalid, 0);
        chk("mr_rdata_rst", mem_rdata, 0);
        @(negedge clk);
        rst = 1'b0; bus_rvalid = 1'b0;
        mem_req = 1'b1; mem_addr = 32'h8000_3008;
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        chk("mr_addr", bus_addr, 64'h8000_3008);
        chk("mr_gnt", mem_gnt, 1);
        @(negedge clk);
        bus_ready = 1'b0; mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h2222;
        #1;
        chk("mr_rvalid", mem_rvalid, 1);
        chk("mr_rdata", mem_rdata, 64'h2222);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1 chk("mr_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
